// File: rtl/vector_list_server_if.sv
// Bundles the draw-side and host-side signals of the double-buffered vector list server.
// The DUT takes the slave modport; the draw master and host use the master modport.
interface vector_list_server_if #(
    parameter int OUT_WIDTH = 8
);
    // inc is a level request: every rising clk edge that samples inc=1 consumes one entry, and
    // the registered outputs show the next entry after that edge. wr_en/commit are taken on the
    // edge unless dropped; full and swap_pending are the only back-pressure the host sees.
    logic                 inc;
    logic [OUT_WIDTH-1:0] o_x;
    logic [OUT_WIDTH-1:0] o_y;
    logic                 o_line;
    logic                 o_pos;
    logic                 frame_done;

    logic                 wr_en;
    logic [OUT_WIDTH-1:0] wr_x;
    logic [OUT_WIDTH-1:0] wr_y;
    logic                 wr_line;
    logic                 wr_pos;
    logic                 commit;
    logic                 full;
    logic                 swap_pending;

    modport slave (
        input  inc, wr_en, wr_x, wr_y, wr_line, wr_pos, commit,
        output o_x, o_y, o_line, o_pos, frame_done, full, swap_pending
    );

    modport master (
        output inc, wr_en, wr_x, wr_y, wr_line, wr_pos, commit,
        input  o_x, o_y, o_line, o_pos, frame_done, full, swap_pending
    );
endinterface

// File: rtl/vector_list_server.sv
// Double-buffered vertex list: the front bank is served to a vector draw master, terminated by
// an end marker, while the host fills the back bank and commits it for a swap at the frame wrap.
module vector_list_server #(
    parameter int OUT_WIDTH = 8,
    parameter int DEPTH     = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    vector_list_server_if.slave bus,
    output logic                dbg_state
);
    localparam int AW = $clog2(DEPTH) + 1;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] DEPTH_L = AW'(DEPTH);

    typedef struct packed {
        logic [OUT_WIDTH-1:0] x;
        logic [OUT_WIDTH-1:0] y;
        logic                 line;
        logic                 pos;
    } entry_t;

    localparam entry_t MARKER = {{OUT_WIDTH{1'b1}}, {OUT_WIDTH{1'b1}}, 1'b0, 1'b1};

    typedef enum logic {
        SHOW = 1'b0,
        MARK = 1'b1
    } state_t;

    entry_t mem [2][DEPTH];

    state_t              state_q, state_d;
    logic                front_sel_q, front_sel_d;
    logic [1:0][AW-1:0]  bank_len_q, bank_len_d;
    logic [AW-1:0]       rd_addr_q, rd_addr_d;
    logic                pending_q, pending_d;
    entry_t              out_q, out_d;
    logic                fd_q, fd_d;

    logic                back_sel;
    logic [AW-1:0]       front_len;
    logic [AW-1:0]       back_len;
    logic [AW-1:0]       rd_next;
    logic [AW-1:0]       new_len;
    logic                write_ok;
    logic                commit_ok;
    entry_t              wr_entry;
    entry_t              entry0;

    always_comb begin
        back_sel    = ~front_sel_q;
        front_len   = bank_len_q[front_sel_q];
        back_len    = bank_len_q[back_sel];
        rd_next     = rd_addr_q + AW'(1);
        wr_entry    = {bus.wr_x, bus.wr_y, bus.wr_line, bus.wr_pos};
        write_ok    = bus.wr_en && !pending_q && (back_len != DEPTH_L);
        commit_ok   = bus.commit && !pending_q;
        new_len     = '0;
        entry0      = MARKER;

        state_d     = state_q;
        front_sel_d = front_sel_q;
        bank_len_d  = bank_len_q;
        rd_addr_d   = rd_addr_q;
        pending_d   = pending_q;
        out_d       = out_q;
        fd_d        = 1'b0;

        // The write lands before any commit on the same edge, so the committed length includes it.
        if (write_ok) bank_len_d[back_sel] = back_len + AW'(1);
        if (commit_ok) pending_d = 1'b1;

        if (bus.inc) begin
            case (state_q)
                SHOW: begin
                    rd_addr_d = rd_next;
                    if (rd_next == front_len) begin
                        state_d = MARK;
                        out_d   = MARKER;
                    end else begin
                        out_d = mem[front_sel_q][rd_next[IW-1:0]];
                    end
                end
                MARK: begin
                    rd_addr_d = '0;
                    fd_d      = 1'b1;
                    if (pending_q || commit_ok) begin
                        // Publish the back bank; a same-edge write to slot 0 is forwarded.
                        front_sel_d            = back_sel;
                        pending_d              = 1'b0;
                        bank_len_d[front_sel_q] = '0;
                        new_len                = write_ok ? back_len + AW'(1) : back_len;
                        entry0                 = (write_ok && back_len == '0) ? wr_entry
                                                                              : mem[back_sel][IW'(0)];
                    end else begin
                        new_len = front_len;
                        entry0  = mem[front_sel_q][IW'(0)];
                    end
                    if (new_len == '0) begin
                        state_d = MARK;
                        out_d   = MARKER;
                    end else begin
                        state_d = SHOW;
                        out_d   = entry0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= MARK;
            front_sel_q <= 1'b0;
            bank_len_q  <= '0;
            rd_addr_q   <= '0;
            pending_q   <= 1'b0;
            out_q       <= MARKER;
            fd_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            front_sel_q <= front_sel_d;
            bank_len_q  <= bank_len_d;
            rd_addr_q   <= rd_addr_d;
            pending_q   <= pending_d;
            out_q       <= out_d;
            fd_q        <= fd_d;
        end
    end

    // Storage is not reset; lengths alone decide what is valid.
    always_ff @(posedge clk) begin
        if (write_ok) mem[back_sel][back_len[IW-1:0]] <= wr_entry;
    end

    assign bus.o_x          = out_q.x;
    assign bus.o_y          = out_q.y;
    assign bus.o_line       = out_q.line;
    assign bus.o_pos        = out_q.pos;
    assign bus.frame_done   = fd_q;
    assign bus.swap_pending = pending_q;
    assign bus.full         = (back_len == DEPTH_L);
    assign dbg_state        = state_q;
endmodule

// File: tb/tb_vector_list_server.sv
// Randomised and directed bench for vector_list_server: a queue-based list model predicts each
// cycle's outputs, and a monitor compares them after every clock edge.
module tb_vector_list_server;
    localparam int W     = 8;
    localparam int DEPTH = 16;
    localparam int RW    = 2 * W + 5;

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         line;
        logic         pos;
    } ent_t;

    localparam ent_t MARKER = {8'hFF, 8'hFF, 1'b0, 1'b1};
    localparam ent_t ZERO   = '0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic dbg_state;

    vector_list_server_if #(.OUT_WIDTH(W)) bus ();

    vector_list_server #(.OUT_WIDTH(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Scoreboard
    logic [RW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the published list, the list being built, and a read position
    // where position == list size means the end marker is showing.
    ent_t front_q[$];
    ent_t back_q[$];
    int   pos = 0;
    bit   pending = 0;

    function automatic ent_t mk(input int x, input int y, input bit l, input bit p);
        ent_t e;
        e.x = W'(x); e.y = W'(y); e.line = l; e.pos = p;
        return e;
    endfunction

    function automatic logic [RW-1:0] act_vec();
        return {bus.o_x, bus.o_y, bus.o_line, bus.o_pos, bus.frame_done, bus.swap_pending, bus.full};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        front_q.delete();
        back_q.delete();
        pos = 0;
        pending = 0;
    endtask

    task automatic step(input bit inc_v, input bit wr_v, input ent_t e, input bit cm_v);
        bit   wr_ok, cm_ok, fd, full_e;
        ent_t o;
        @(negedge clk);
        bus.inc = inc_v; bus.wr_en = wr_v; bus.commit = cm_v;
        bus.wr_x = e.x; bus.wr_y = e.y; bus.wr_line = e.line; bus.wr_pos = e.pos;
        wr_ok = wr_v && !pending && (back_q.size() < DEPTH);
        if (wr_ok) back_q.push_back(e);
        cm_ok = cm_v && !pending;
        fd = 0;
        if (inc_v) begin
            if (pos < front_q.size()) begin
                pos++;
            end else begin
                fd = 1;
                pos = 0;
                if (pending || cm_ok) begin
                    front_q = back_q;
                    back_q.delete();
                    pending = 0;
                    cm_ok = 0;
                end
            end
        end
        if (cm_ok) pending = 1;
        o = (pos < front_q.size()) ? front_q[pos] : MARKER;
        full_e = (back_q.size() == DEPTH);
        exp_q.push_back({o, fd, pending, full_e});
        @(posedge clk);
        #2;
        bus.inc = 0; bus.wr_en = 0; bus.commit = 0;
    endtask

    task automatic idle();
        step(0, 0, ZERO, 0);
    endtask

    task automatic adv();
        step(1, 0, ZERO, 0);
    endtask

    task automatic adv_to_marker();
        for (int i = 0; i < DEPTH + 2 && pos < front_q.size(); i++) adv();
    endtask

    task automatic flush_pending();
        for (int i = 0; i < DEPTH + 3 && pending; i++) adv();
    endtask

    // Monitor: one expected entry per driven cycle, compared just after the edge.
    initial begin
        logic [RW-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("served", 32'(act_vec()), 32'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.inc = 0; bus.wr_en = 0; bus.commit = 0;
        bus.wr_x = '0; bus.wr_y = '0; bus.wr_line = 0; bus.wr_pos = 0;
        model_reset();
        #12;
        check("reset_out", 32'(act_vec()), 32'({MARKER, 3'b000}));
        check("reset_state", 32'(dbg_state), 32'(1));
        @(negedge clk);
        rst_n = 1'b1;
        idle();

        // Empty front: every inc shows the marker and pulses frame_done.
        for (int i = 0; i < 3; i++) begin
            adv();
            idle();
        end

        // Three-vertex frame, publish, and two full passes.
        step(0, 1, mk(174, 162, 1, 0), 0);
        step(0, 1, mk(161, 147, 1, 0), 0);
        step(0, 1, mk(92, 148, 0, 1), 0);
        step(0, 0, ZERO, 1);
        for (int i = 0; i < 9; i++) adv();

        // Commit while the front is mid-frame; later write and commit are ignored until the wrap.
        step(0, 1, mk(10, 20, 1, 0), 0);
        step(0, 1, mk(30, 40, 0, 1), 0);
        step(0, 0, ZERO, 1);
        step(0, 1, mk(50, 60, 1, 1), 1);
        idle();
        adv_to_marker();
        adv();
        adv();
        adv();

        // Seventeen writes into a 16-deep bank; the last is dropped.
        for (int i = 0; i < 17; i++) step(0, 1, mk(i * 7 + 3, 200 - i, i[0], ~i[0]), 0);
        step(0, 0, ZERO, 1);
        adv_to_marker();
        for (int i = 0; i < DEPTH + 2; i++) adv();

        // Committing an empty back bank publishes a marker-only frame.
        adv_to_marker();
        step(0, 0, ZERO, 1);
        adv();
        adv();

        // Commit on the marker-wrap edge, with a same-edge write into slot 0.
        adv_to_marker();
        step(1, 1, mk(77, 88, 1, 0), 1);
        adv();
        adv();

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 40,
                 mk($urandom_range(0, 255), $urandom_range(0, 255),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))),
                 $urandom_range(0, 99) < 8);
        end

        // Asynchronous reset mid-frame with a commit pending.
        flush_pending();
        adv_to_marker();
        step(0, 1, mk(1, 2, 1, 0), 0);
        step(0, 1, mk(3, 4, 1, 0), 0);
        step(0, 1, mk(5, 6, 0, 1), 1);
        adv();
        step(0, 1, mk(9, 9, 1, 0), 1);
        adv();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_out", 32'(act_vec()), 32'({MARKER, 3'b000}));
        check("async_state", 32'(dbg_state), 32'(1));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        adv();
        adv();
        idle();

        idle();
        check("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/vector_list_server.md
VECTOR_LIST_SERVER -- requirements
Module: vector_list_server

Interface
REQ-001 SHALL have parameter OUT_WIDTH, default 8, coordinate width of stored and served vertices.
REQ-002 SHALL have parameter DEPTH, default 16, vertex capacity per bank, with AW = $clog2(DEPTH)+1 used internally for length and pointer width.
REQ-003 SHALL use one clock; reset is asynchronous and active-low: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have inc  in  1  advance request from the vector draw master, one entry per cycle held high.
REQ-005 SHALL have o_x, o_y  out  OUT_WIDTH  served vertex coordinates, wired to the master's i_x/i_y.
REQ-006 SHALL have o_line  out  1 (draw line to vertex) and o_pos  out  1 (move without drawing).
REQ-007 SHALL have wr_en  in  1, wr_x/wr_y  in  OUT_WIDTH, wr_line/wr_pos  in  1: host append to the back bank.
REQ-008 SHALL have commit  in  1  host request to publish the back bank.
REQ-009 SHALL have full  out  1, swap_pending  out  1, frame_done  out  1 (single-cycle pulse).

Function
REQ-010 SHALL hold two banks of DEPTH entries {x,y,line,pos}, each with a length register; the front bank is served and the back bank is written.
REQ-011 SHALL use a read FSM with states SHOW (rd_addr < front_len, serve front[rd_addr]) and MARK (serve end marker x=y=all-ones, line=0, pos=1).
REQ-012 SHALL drive all served outputs from registers; on a clk edge with inc=1, the outputs show the next entry after that edge (1-cycle latency); with inc=0, the outputs hold.
REQ-013 SHALL, on inc in SHOW: rd_addr+1, going to MARK if rd_addr+1 == front_len, otherwise staying in SHOW.
REQ-014 SHALL, on inc in MARK: wrap rd_addr to 0, pulse frame_done for one cycle, and go to SHOW (or stay in MARK if the new front_len is 0).
REQ-015 SHALL, on the MARK-to-wrap edge with swap_pending=1, swap banks, clear swap_pending, zero the new back length and write pointer, and serve entry 0 of the newly published bank on that same edge.
REQ-016 SHALL, on wr_en with swap_pending=0 and back_len < DEPTH, write the entry at back[back_len] and increment back_len.
REQ-017 SHALL silently drop wr_en when back_len == DEPTH or swap_pending=1, with no state change.
REQ-018 SHALL assert full combinationally when back_len == DEPTH.
REQ-019 SHALL, on commit with swap_pending=0, set swap_pending; commit while pending SHALL be ignored; commit with back_len=0 is legal and publishes an empty frame (marker only).
REQ-020 SHALL, for commit and the MARK-wrap inc in the same cycle, perform the swap on that edge with swap_pending never visibly set.
REQ-021 SHALL, for wr_en and commit in the same cycle with swap_pending=0, store the write first, so the committed length includes it.
REQ-022 SHALL keep the front bank contents unchanged by host writes at all times.

Reset
REQ-023 SHALL, while rst_n=0 regardless of clk: front=bank0; both lengths, rd_addr and write pointer =0; FSM=MARK; o_x=o_y=all-ones, o_line=0, o_pos=1; full=0, swap_pending=0, frame_done=0.
REQ-024 SHALL NOT require bank storage contents to be reset.
REQ-025 SHALL, on reset asserted mid-frame or mid-swap, discard pending commit and all host writes, returning to the REQ-023 state.

Verification
REQ-026 Bench SHALL cover: reset, inc pulsed 3 times -> outputs stay (255,255,0,1); frame_done pulses on each inc.
REQ-027 Bench SHALL cover: write (174,162,1,0),(161,147,1,0),(92,148,0,1), commit, pulse inc until wrap -> swap; o = (174,162,1,0), then successive incs give (161,147,1,0), (92,148,0,1), (255,255,0,1), then wrap to (174,162,1,0) with frame_done.
REQ-028 Bench SHALL cover: 17 writes with DEPTH=16 -> full=1 after the 16th; the 17th is dropped; after publish the frame shows 16 entries plus the marker.
REQ-029 Bench SHALL cover: commit issued while front is in SHOW, then wr_en and a second commit -> write and second commit ignored; the swap occurs only at the marker wrap.
REQ-030 Bench SHALL cover: commit coincident with the marker-wrap inc -> new bank entry 0 served on that edge, swap_pending stays 0.
REQ-031 Bench SHALL cover: rst_n driven low asynchronously mid-frame between clk edges -> outputs are immediately (255,255,0,1) and swap_pending=0.
